// File: rtl/tage_table_assoc_if.sv
// Signal bundle between the TAGE predictor and one tagged component table.
// Latency: none (wires only).
// Backpressure: none; the table accepts a lookup and a write every cycle.
interface tage_table_assoc_if #(
    parameter int AW       = 6,
    parameter int WW       = 1,
    parameter int TAG_SIZE = 8
);
    logic                IN_readValid;
    logic [AW-1:0]       IN_readAddr;
    logic [TAG_SIZE-1:0] IN_readTag;
    logic                OUT_readValid;
    logic                OUT_readTaken;
    logic                OUT_readWeak;
    logic [WW-1:0]       OUT_readWay;
    logic                IN_writeValid;
    logic [AW-1:0]       IN_writeAddr;
    logic [TAG_SIZE-1:0] IN_writeTag;
    logic [WW-1:0]       IN_writeWay;
    logic                IN_writeTaken;
    logic                IN_writeUpdate;
    logic                IN_writeNew;
    logic                IN_writeUseful;
    logic                IN_anyAlloc;
    logic                OUT_writeAlloc;
    logic [WW-1:0]       OUT_allocWay;

    modport master (
        output IN_readValid, IN_readAddr, IN_readTag,
        output IN_writeValid, IN_writeAddr, IN_writeTag, IN_writeWay, IN_writeTaken,
        output IN_writeUpdate, IN_writeNew, IN_writeUseful, IN_anyAlloc,
        input  OUT_readValid, OUT_readTaken, OUT_readWeak, OUT_readWay,
        input  OUT_writeAlloc, OUT_allocWay
    );

    modport slave (
        input  IN_readValid, IN_readAddr, IN_readTag,
        input  IN_writeValid, IN_writeAddr, IN_writeTag, IN_writeWay, IN_writeTaken,
        input  IN_writeUpdate, IN_writeNew, IN_writeUseful, IN_anyAlloc,
        output OUT_readValid, OUT_readTaken, OUT_readWeak, OUT_readWay,
        output OUT_writeAlloc, OUT_allocWay
    );
endinterface

// File: rtl/tage_table_assoc.sv
// Set-associative TAGE tagged table; TAGE_RD_BYPASS_EN forwards same-cycle writes to the lookup.
// Latency: lookup registered one cycle after request; allocation verdict is combinational.
// Backpressure: none; one lookup and one update/allocation accepted every cycle.
module tage_table_assoc #(
    parameter int SIZE     = 64,
    parameter int WAYS     = 2,
    parameter int TAG_SIZE = 8,
    parameter int USF_SIZE = 2,
    parameter int CNT_SIZE = 3,
    parameter int INTERVAL = 20
) (
    input  logic              clk,
    input  logic              rst,
    tage_table_assoc_if.slave io
);
    localparam int AW = $clog2(SIZE);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CNT_SIZE-1:0] CNT_WT  = {1'b1, {(CNT_SIZE-1){1'b0}}};
    localparam logic [CNT_SIZE-1:0] CNT_WN  = {1'b0, {(CNT_SIZE-1){1'b1}}};
    localparam logic [CNT_SIZE-1:0] CNT_ONE = {{(CNT_SIZE-1){1'b0}}, 1'b1};
    localparam logic [USF_SIZE-1:0] USF_ONE = {{(USF_SIZE-1){1'b0}}, 1'b1};
    localparam logic [INTERVAL-1:0] TMR_ONE = {{(INTERVAL-1){1'b0}}, 1'b1};

    logic                r_valid  [SIZE][WAYS];
    logic [TAG_SIZE-1:0] r_tag    [SIZE][WAYS];
    logic [USF_SIZE-1:0] r_useful [SIZE][WAYS];
    logic [CNT_SIZE-1:0] r_cnt    [SIZE][WAYS];
    logic [INTERVAL-1:0] r_timer;

    logic                r_rd_vld;
    logic                r_rd_taken;
    logic                r_rd_weak;
    logic [WW-1:0]       r_rd_way;

    logic                w_decay;
    logic                w_alloc_req;
    logic                w_inv_found;
    logic [WW-1:0]       w_inv_way;
    logic                w_zu_found;
    logic [WW-1:0]       w_zu_way;
    logic                w_alloc_ok;
    logic [WW-1:0]       w_alloc_way;

    logic                w_row_we    [WAYS];
    logic                w_row_valid [WAYS];
    logic [TAG_SIZE-1:0] w_row_tag   [WAYS];
    logic [USF_SIZE-1:0] w_row_use   [WAYS];
    logic [CNT_SIZE-1:0] w_row_cnt   [WAYS];

    logic                w_rs_valid  [WAYS];
    logic [TAG_SIZE-1:0] w_rs_tag    [WAYS];
    logic [CNT_SIZE-1:0] w_rs_cnt    [WAYS];
    logic                w_hit;
    logic [WW-1:0]       w_hit_way;
    logic [CNT_SIZE-1:0] w_hit_cnt;

    assign w_decay = (r_timer == '0);

    // Scan downwards so the lowest-index candidate is the one left standing.
    always_comb begin
        w_alloc_req = io.IN_writeValid & ~io.IN_writeUpdate & io.IN_writeNew;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        w_zu_found  = 1'b0;
        w_zu_way    = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!r_valid[io.IN_writeAddr][i]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WW'(i);
            end
            if (r_useful[io.IN_writeAddr][i] == '0) begin
                w_zu_found = 1'b1;
                w_zu_way   = WW'(i);
            end
        end
        w_alloc_ok  = w_alloc_req & (w_inv_found | w_zu_found);
        w_alloc_way = '0;
        if (w_alloc_ok) begin
            w_alloc_way = w_inv_found ? w_inv_way : w_zu_way;
        end
    end

    assign io.OUT_writeAlloc = w_alloc_ok;
    assign io.OUT_allocWay   = w_alloc_way;

    // Post-write image of the addressed set; w_row_we marks the ways that change.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            w_row_we[w]    = 1'b0;
            w_row_valid[w] = r_valid[io.IN_writeAddr][w];
            w_row_tag[w]   = r_tag[io.IN_writeAddr][w];
            w_row_use[w]   = r_useful[io.IN_writeAddr][w];
            w_row_cnt[w]   = r_cnt[io.IN_writeAddr][w];
        end
        if (io.IN_writeValid) begin
            if (io.IN_writeUpdate) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WW'(w) == io.IN_writeWay) begin
                        w_row_we[w] = 1'b1;
                        if (io.IN_writeTaken) begin
                            if (w_row_cnt[w] != '1) w_row_cnt[w] = w_row_cnt[w] + CNT_ONE;
                        end else begin
                            if (w_row_cnt[w] != '0) w_row_cnt[w] = w_row_cnt[w] - CNT_ONE;
                        end
                        if (io.IN_writeUseful) begin
                            if (w_row_use[w] != '1) w_row_use[w] = w_row_use[w] + USF_ONE;
                        end else begin
                            if (w_row_use[w] != '0) w_row_use[w] = w_row_use[w] - USF_ONE;
                        end
                    end
                end
            end else if (io.IN_writeNew) begin
                if (w_alloc_ok) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WW'(w) == w_alloc_way) begin
                            w_row_we[w]    = 1'b1;
                            w_row_valid[w] = 1'b1;
                            w_row_tag[w]   = io.IN_writeTag;
                            w_row_use[w]   = '0;
                            w_row_cnt[w]   = io.IN_writeTaken ? CNT_WT : CNT_WN;
                        end
                    end
                end else if (!io.IN_anyAlloc) begin
                    for (int w = 0; w < WAYS; w++) begin
                        w_row_we[w] = 1'b1;
                        if (w_row_use[w] != '0) w_row_use[w] = w_row_use[w] - USF_ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            w_rs_valid[w] = r_valid[io.IN_readAddr][w];
            w_rs_tag[w]   = r_tag[io.IN_readAddr][w];
            w_rs_cnt[w]   = r_cnt[io.IN_readAddr][w];
`ifdef TAGE_RD_BYPASS_EN
            if (io.IN_readAddr == io.IN_writeAddr && w_row_we[w]) begin
                w_rs_valid[w] = w_row_valid[w];
                w_rs_tag[w]   = w_row_tag[w];
                w_rs_cnt[w]   = w_row_cnt[w];
            end
`endif
        end
    end

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_hit_cnt = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (w_rs_valid[i] && w_rs_tag[i] == io.IN_readTag) begin
                w_hit     = 1'b1;
                w_hit_way = WW'(i);
                w_hit_cnt = w_rs_cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_vld   <= 1'b0;
            r_rd_taken <= 1'b0;
            r_rd_weak  <= 1'b0;
            r_rd_way   <= '0;
        end else begin
            r_rd_vld <= io.IN_readValid & w_hit;
            if (io.IN_readValid) begin
                r_rd_taken <= w_hit_cnt[CNT_SIZE-1];
                r_rd_weak  <= w_hit & ((w_hit_cnt == CNT_WT) | (w_hit_cnt == CNT_WN));
                r_rd_way   <= w_hit_way;
            end
        end
    end

    assign io.OUT_readValid = r_rd_vld;
    assign io.OUT_readTaken = r_rd_taken;
    assign io.OUT_readWeak  = r_rd_weak;
    assign io.OUT_readWay   = r_rd_way;

    // A write to an entry overrides the decay of that entry in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
            for (int s = 0; s < SIZE; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w]  <= 1'b0;
                    r_tag[s][w]    <= '0;
                    r_useful[s][w] <= '0;
                    r_cnt[s][w]    <= '0;
                end
            end
        end else begin
            r_timer <= r_timer - TMR_ONE;
            for (int s = 0; s < SIZE; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AW'(s) == io.IN_writeAddr && w_row_we[w]) begin
                        r_valid[s][w]  <= w_row_valid[w];
                        r_tag[s][w]    <= w_row_tag[w];
                        r_useful[s][w] <= w_row_use[w];
                        r_cnt[s][w]    <= w_row_cnt[w];
                    end else if (w_decay && r_useful[s][w] != '0) begin
                        r_useful[s][w] <= r_useful[s][w] - USF_ONE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tage_table_assoc.sv
// Directed bench for tage_table_assoc: vector table on a long-interval instance, decay on a short one.
// Expectations follow TAGE_RD_BYPASS_EN when defined.
module tb_tage_table_assoc;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
`ifdef TAGE_RD_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;
    int   kb;

    always #5 clk = ~clk;

    tage_table_assoc_if #(.AW(6), .WW(1), .TAG_SIZE(8)) ifa ();
    tage_table_assoc_if #(.AW(6), .WW(1), .TAG_SIZE(8)) ifb ();

    tage_table_assoc #(.SIZE(64), .WAYS(2), .TAG_SIZE(8), .USF_SIZE(2), .CNT_SIZE(3), .INTERVAL(16))
        dut_a (.clk(clk), .rst(rst_n), .io(ifa.slave));
    tage_table_assoc #(.SIZE(64), .WAYS(2), .TAG_SIZE(8), .USF_SIZE(2), .CNT_SIZE(3), .INTERVAL(4))
        dut_b (.clk(clk), .rst(rst_n), .io(ifb.slave));

    // Edge index since reset release; short-interval decay fires on edges where kb % 16 == 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) kb <= 0;
        else        kb <= kb + 1;
    end

    typedef struct {
        logic rv; logic [5:0] ra; logic [7:0] rt;
        logic wv; logic [5:0] wa; logic [7:0] wt; logic ww;
        logic tk; logic up; logic nw; logic us; logic an;
        logic e_al; logic e_aw;
        logic e_rv; logic e_tk; logic e_wk; logic e_way;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic rv, input logic [5:0] ra, input logic [7:0] rt,
        input logic wv, input logic [5:0] wa, input logic [7:0] wt, input logic ww,
        input logic tk, input logic up, input logic nw, input logic us, input logic an,
        input logic e_al, input logic e_aw,
        input logic e_rv, input logic e_tk, input logic e_wk, input logic e_way);
        vec_t v;
        v.rv = rv; v.ra = ra; v.rt = rt;
        v.wv = wv; v.wa = wa; v.wt = wt; v.ww = ww;
        v.tk = tk; v.up = up; v.nw = nw; v.us = us; v.an = an;
        v.e_al = e_al; v.e_aw = e_aw;
        v.e_rv = e_rv; v.e_tk = e_tk; v.e_wk = e_wk; v.e_way = e_way;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive_a(input vec_t v);
        ifa.IN_readValid   = v.rv;
        ifa.IN_readAddr    = v.ra;
        ifa.IN_readTag     = v.rt;
        ifa.IN_writeValid  = v.wv;
        ifa.IN_writeAddr   = v.wa;
        ifa.IN_writeTag    = v.wt;
        ifa.IN_writeWay    = v.ww;
        ifa.IN_writeTaken  = v.tk;
        ifa.IN_writeUpdate = v.up;
        ifa.IN_writeNew    = v.nw;
        ifa.IN_writeUseful = v.us;
        ifa.IN_anyAlloc    = v.an;
    endtask

    task automatic idle_b();
        ifb.IN_readValid = L; ifb.IN_readAddr = '0; ifb.IN_readTag = '0;
        ifb.IN_writeValid = L; ifb.IN_writeAddr = '0; ifb.IN_writeTag = '0; ifb.IN_writeWay = L;
        ifb.IN_writeTaken = L; ifb.IN_writeUpdate = L; ifb.IN_writeNew = L;
        ifb.IN_writeUseful = L; ifb.IN_anyAlloc = L;
    endtask

    task automatic b_wr(input logic [5:0] a, input logic [7:0] t, input logic up, input logic us);
        ifb.IN_writeValid = H; ifb.IN_writeAddr = a; ifb.IN_writeTag = t; ifb.IN_writeWay = L;
        ifb.IN_writeTaken = H; ifb.IN_writeUpdate = up; ifb.IN_writeNew = ~up;
        ifb.IN_writeUseful = us; ifb.IN_anyAlloc = L;
        @(negedge clk);
        ifb.IN_writeValid = L;
    endtask

    task automatic chk_use(input string nm, input logic [1:0] e1, input logic [1:0] e2,
                           input logic [1:0] e3, input logic [1:0] e4);
        check({nm, "_s1"}, 1, 32'(dut_b.r_useful[1][0]), 32'(e1));
        check({nm, "_s2"}, 2, 32'(dut_b.r_useful[2][0]), 32'(e2));
        check({nm, "_s3"}, 3, 32'(dut_b.r_useful[3][0]), 32'(e3));
        check({nm, "_s4"}, 4, 32'(dut_b.r_useful[4][0]), 32'(e4));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c;
        logic tkv, wkv;
        vec_t idle_v;
        idle_v = mk(L, 6'd0, 8'h00, L, 6'd0, 8'h00, L, L, L, L, L, L, L, L, L, L, L, L);

        // set 5: allocation, hold behaviour, replacement of a zero-useful way
        vt.push_back(mk(H, 6'd5, 8'h3C, L, 6'd0, 8'h00, L, L, L, L, L, L, L, L, L, L, L, L));
        vt.push_back(mk(L, 6'd0, 8'h00, H, 6'd5, 8'h3C, L, H, L, H, L, L, H, L, L, L, L, L));
        vt.push_back(mk(H, 6'd5, 8'h3C, L, 6'd0, 8'h00, L, L, L, L, L, L, L, L, H, H, H, L));
        vt.push_back(mk(L, 6'd0, 8'h00, H, 6'd5, 8'h11, L, L, L, H, L, L, H, H, L, H, H, L));
        vt.push_back(mk(H, 6'd5, 8'h11, L, 6'd0, 8'h00, L, L, L, L, L, L, L, L, H, L, H, H));
        vt.push_back(mk(L, 6'd0, 8'h00, H, 6'd5, 8'h22, L, H, L, H, L, L, H, L, L, L, H, H));
        vt.push_back(mk(H, 6'd5, 8'h3C, L, 6'd0, 8'h00, L, L, L, L, L, L, L, L, L, L, L, L));
        vt.push_back(mk(H, 6'd5, 8'h22, L, 6'd0, 8'h00, L, L, L, L, L, L, L, L, H, H, H, L));
        // counter saturation: 8 taken then 8 not-taken updates with a same-cycle read
        for (int i = 0; i < 8; i++) begin
            c = (4 + i > 7) ? 7 : 4 + i;
            if (BYP) c = (c + 1 > 7) ? 7 : c + 1;
            tkv = (c >= 4);
            wkv = (c == 4) || (c == 3);
            vt.push_back(mk(H, 6'd5, 8'h22, H, 6'd5, 8'h00, L, H, H, L, L, L, L, L, H, tkv, wkv, L));
        end
        for (int i = 0; i < 8; i++) begin
            c = 7 - i;
            if (BYP) c = c - 1;
            tkv = (c >= 4);
            wkv = (c == 4) || (c == 3);
            vt.push_back(mk(H, 6'd5, 8'h22, H, 6'd5, 8'h00, L, L, H, L, L, L, L, L, H, tkv, wkv, L));
        end
        vt.push_back(mk(H, 6'd5, 8'h22, L, 6'd0, 8'h00, L, L, L, L, L, L, L, L, H, L, L, L));
        // set 7: full set, anyAlloc suppression, useful aging, retry
        vt.push_back(mk(L, 6'd0, 8'h00, H, 6'd7, 8'hA1, L, H, L, H, L, L, H, L, L, L, L, L));
        vt.push_back(mk(L, 6'd0, 8'h00, H, 6'd7, 8'hA2, L, H, L, H, L, L, H, H, L, L, L, L));
        vt.push_back(mk(L, 6'd0, 8'h00, H, 6'd7, 8'h00, L, H, H, L, H, L, L, L, L, L, L, L));
        vt.push_back(mk(L, 6'd0, 8'h00, H, 6'd7, 8'h00, H, H, H, L, H, L, L, L, L, L, L, L));
        vt.push_back(mk(L, 6'd0, 8'h00, H, 6'd7, 8'hA3, L, L, L, H, L, H, L, L, L, L, L, L));
        vt.push_back(mk(L, 6'd0, 8'h00, H, 6'd7, 8'hA3, L, L, L, H, L, L, L, L, L, L, L, L));
        vt.push_back(mk(L, 6'd0, 8'h00, H, 6'd7, 8'hA3, L, L, L, H, L, L, H, L, L, L, L, L));
        vt.push_back(mk(H, 6'd7, 8'hA3, L, 6'd0, 8'h00, L, L, L, L, L, L, L, L, H, L, H, L));
        vt.push_back(mk(H, 6'd7, 8'hA2, L, 6'd0, 8'h00, L, L, L, L, L, L, L, L, H, H, L, H));
        // set 8: duplicate tags, lowest way wins
        vt.push_back(mk(L, 6'd0, 8'h00, H, 6'd8, 8'h55, L, H, L, H, L, L, H, L, L, H, L, H));
        vt.push_back(mk(L, 6'd0, 8'h00, H, 6'd8, 8'h55, L, L, L, H, L, L, H, H, L, H, L, H));
        vt.push_back(mk(H, 6'd8, 8'h55, L, 6'd0, 8'h00, L, L, L, L, L, L, L, L, H, H, H, L));
        // set 9: ignored write, then same-cycle read and allocation
        vt.push_back(mk(L, 6'd0, 8'h00, L, 6'd9, 8'h77, L, H, L, H, L, L, L, L, L, H, H, L));
        vt.push_back(mk(H, 6'd9, 8'h77, H, 6'd9, 8'h77, L, H, L, H, L, L, H, L, BYP, BYP, BYP, L));
        vt.push_back(mk(H, 6'd9, 8'h77, L, 6'd0, 8'h00, L, L, L, L, L, L, L, L, H, H, H, L));

        rst_n = 1'b0;
        drive_a(idle_v);
        idle_b();
        repeat (3) @(negedge clk);
        check("rst_rd_vld", 0, 32'(ifa.OUT_readValid), 32'(L));
        check("rst_rd_tk",  0, 32'(ifa.OUT_readTaken), 32'(L));
        check("rst_rd_wk",  0, 32'(ifa.OUT_readWeak),  32'(L));
        check("rst_rd_way", 0, 32'(ifa.OUT_readWay),   32'(L));
        rst_n = 1'b1;

        foreach (vt[i]) begin
            @(negedge clk);
            drive_a(vt[i]);
            #1;
            check("alloc",     i, 32'(ifa.OUT_writeAlloc), 32'(vt[i].e_al));
            check("alloc_way", i, 32'(ifa.OUT_allocWay),   32'(vt[i].e_aw));
            @(posedge clk);
            #1;
            check("rd_vld", i, 32'(ifa.OUT_readValid), 32'(vt[i].e_rv));
            check("rd_tk",  i, 32'(ifa.OUT_readTaken), 32'(vt[i].e_tk));
            check("rd_wk",  i, 32'(ifa.OUT_readWeak),  32'(vt[i].e_wk));
            check("rd_way", i, 32'(ifa.OUT_readWay),   32'(vt[i].e_way));
        end
        @(negedge clk);
        drive_a(idle_v);

        // decay on the short-interval table: align so writes finish before the next decay edge
        for (int g = 0; g < 40 && (kb % 16) != 1; g++) @(negedge clk);
        if ((kb % 16) != 1) begin
            n_fail++;
            $display("FAIL decay_align: edge index %0d, want residue 1", kb);
        end
        for (int s = 1; s <= 3; s++) b_wr(6'(s), 8'(64 + s), L, L);
        for (int r = 0; r < 3; r++)
            for (int s = 1; s <= 3; s++) b_wr(6'(s), 8'h00, H, H);
        repeat (3) @(negedge clk);
        chk_use("pre_decay", 2'd3, 2'd3, 2'd3, 2'd0);
        b_wr(6'd1, 8'h00, H, H);
        chk_use("post_decay", 2'd3, 2'd2, 2'd2, 2'd0);
        ifb.IN_readValid = H; ifb.IN_readAddr = 6'd2; ifb.IN_readTag = 8'h42;
        @(negedge clk);
        ifb.IN_readValid = L;
        check("decay_rd_vld", 0, 32'(ifb.OUT_readValid), 32'(H));
        check("decay_rd_tk",  0, 32'(ifb.OUT_readTaken), 32'(H));
        check("decay_rd_wk",  0, 32'(ifb.OUT_readWeak),  32'(L));

        // asynchronous reset mid-stream, write during reset is dropped
        drive_a(mk(H, 6'd9, 8'h77, L, 6'd0, 8'h00, L, L, L, L, L, L, L, L, L, L, L, L));
        @(posedge clk);
        #1;
        drive_a(idle_v);
        check("pre_rst_vld", 0, 32'(ifa.OUT_readValid), 32'(H));
        check("pre_rst_tk",  0, 32'(ifa.OUT_readTaken), 32'(H));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vld", 0, 32'(ifa.OUT_readValid), 32'(L));
        check("arst_tk",  0, 32'(ifa.OUT_readTaken), 32'(L));
        check("arst_wk",  0, 32'(ifa.OUT_readWeak),  32'(L));
        check("arst_way", 0, 32'(ifa.OUT_readWay),   32'(L));
        drive_a(mk(L, 6'd0, 8'h00, H, 6'd10, 8'h66, L, H, L, H, L, L, L, L, L, L, L, L));
        @(posedge clk);
        #1;
        drive_a(idle_v);
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(mk(H, 6'd10, 8'h66, L, 6'd0, 8'h00, L, L, L, L, L, L, L, L, L, L, L, L));
        @(posedge clk);
        #1;
        check("post_rst_rd10", 0, 32'(ifa.OUT_readValid), 32'(L));
        drive_a(mk(H, 6'd9, 8'h77, L, 6'd0, 8'h00, L, L, L, L, L, L, L, L, L, L, L, L));
        @(posedge clk);
        #1;
        check("post_rst_rd9", 0, 32'(ifa.OUT_readValid), 32'(L));
        drive_a(idle_v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
